// File: rtl/dnn_mac_sched.sv
// dnn_mac_sched: sequencer for the 4-4-2 DNN inference datapath.
// Time-multiplexes one shared MAC over all 24 weights and emits operand
// selects, accumulator strobes and writeback strobes, then pulses
// out0_ready/out1_ready as the output registers are written.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_ready        start request, sampled only while idle
//   stall           datapath back-pressure; presented op is not consumed
//   busy            inference in progress
//   layer           0 = input->hidden, 1 = hidden->output
//   src_idx         source operand index
//   dst_idx         destination neuron index within the layer
//   acc_clr/acc_en  accumulator load / accumulate strobes
//   h_we/out_we     hidden / output register writeback strobes
//   out0_ready/out1_ready  one-cycle pulse after the output write lands
module dnn_mac_sched #(
   parameter int unsigned ACC_LAT = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_ready,
   input  logic       stall,
   output logic       busy,
   output logic       layer,
   output logic [1:0] src_idx,
   output logic [1:0] dst_idx,
   output logic       acc_clr,
   output logic       acc_en,
   output logic       h_we,
   output logic       out_we,
   output logic       out0_ready,
   output logic       out1_ready
);

   localparam int unsigned IDX_W = 2;
   localparam int unsigned CNT_W = 3;
   localparam bit HAS_DRAIN = (ACC_LAT != 0);
   localparam logic [CNT_W-1:0] DRAIN_LAST = HAS_DRAIN ? CNT_W'(ACC_LAT - 1) : '0;

   typedef enum logic [1:0] {IDLE, MAC, DRAIN, WB} state_t;

   // The state/counters describe the op that will be presented next; the
   // output registers hold the op currently presented to the datapath.
   state_t           state, state_d;
   logic             cnt_layer, cnt_layer_d;
   logic [IDX_W-1:0] cnt_src, cnt_src_d;
   logic [IDX_W-1:0] cnt_dst, cnt_dst_d;
   logic [CNT_W-1:0] drain_cnt, drain_cnt_d;

   logic             busy_d, layer_d, acc_clr_d, acc_en_d, h_we_d, out_we_d;
   logic [IDX_W-1:0] src_idx_d, dst_idx_d;
   logic             out0_ready_d, out1_ready_d;

   // Next-state and next-output logic
   always_comb begin
      state_d      = state;
      cnt_layer_d  = cnt_layer;
      cnt_src_d    = cnt_src;
      cnt_dst_d    = cnt_dst;
      drain_cnt_d  = drain_cnt;
      busy_d       = busy;
      layer_d      = layer;
      src_idx_d    = src_idx;
      dst_idx_d    = dst_idx;
      acc_clr_d    = acc_clr;
      acc_en_d     = acc_en;
      h_we_d       = h_we;
      out_we_d     = out_we;
      // Ready pulses follow the consuming edge of an output writeback only.
      out0_ready_d = out_we && (dst_idx == IDX_W'(0)) && !stall;
      out1_ready_d = out_we && (dst_idx == IDX_W'(1)) && !stall;

      // Stall only matters while an op is actually presented.
      if (!stall || !busy) begin
         busy_d    = (state != IDLE);
         layer_d   = cnt_layer;
         src_idx_d = cnt_src;
         dst_idx_d = cnt_dst;
         acc_clr_d = (state == MAC) && (cnt_src == IDX_W'(0));
         acc_en_d  = (state == MAC) && (cnt_src != IDX_W'(0));
         h_we_d    = (state == WB) && !cnt_layer;
         out_we_d  = (state == WB) && cnt_layer;

         unique case (state)
            IDLE: begin
               if (in_ready) begin
                  state_d     = MAC;
                  cnt_layer_d = 1'b0;
                  cnt_src_d   = '0;
                  cnt_dst_d   = '0;
               end
            end
            MAC: begin
               if (cnt_src == IDX_W'(3)) begin
                  if (HAS_DRAIN) begin
                     state_d     = DRAIN;
                     drain_cnt_d = DRAIN_LAST;
                  end else begin
                     state_d = WB;
                  end
               end else begin
                  cnt_src_d = cnt_src + IDX_W'(1);
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) state_d = WB;
               else                 drain_cnt_d = drain_cnt - CNT_W'(1);
            end
            WB: begin
               cnt_src_d = '0;
               state_d   = MAC;
               if (!cnt_layer) begin
                  if (cnt_dst == IDX_W'(3)) begin
                     cnt_layer_d = 1'b1;
                     cnt_dst_d   = '0;
                  end else begin
                     cnt_dst_d = cnt_dst + IDX_W'(1);
                  end
               end else if (cnt_dst == IDX_W'(1)) begin
                  // Counters return to zero so the idle outputs read as zero.
                  state_d     = IDLE;
                  cnt_layer_d = 1'b0;
                  cnt_dst_d   = '0;
               end else begin
                  cnt_dst_d = cnt_dst + IDX_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State, counter and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt_layer  <= 1'b0;
         cnt_src    <= '0;
         cnt_dst    <= '0;
         drain_cnt  <= '0;
         busy       <= 1'b0;
         layer      <= 1'b0;
         src_idx    <= '0;
         dst_idx    <= '0;
         acc_clr    <= 1'b0;
         acc_en     <= 1'b0;
         h_we       <= 1'b0;
         out_we     <= 1'b0;
         out0_ready <= 1'b0;
         out1_ready <= 1'b0;
      end else begin
         state      <= state_d;
         cnt_layer  <= cnt_layer_d;
         cnt_src    <= cnt_src_d;
         cnt_dst    <= cnt_dst_d;
         drain_cnt  <= drain_cnt_d;
         busy       <= busy_d;
         layer      <= layer_d;
         src_idx    <= src_idx_d;
         dst_idx    <= dst_idx_d;
         acc_clr    <= acc_clr_d;
         acc_en     <= acc_en_d;
         h_we       <= h_we_d;
         out_we     <= out_we_d;
         out0_ready <= out0_ready_d;
         out1_ready <= out1_ready_d;
      end
   end

endmodule

// File: doc/dnn_mac_sched.md
# dnn_mac_sched

Sequencing controller for the 4-4-2 DNN inference datapath. It time-multiplexes one shared multiply-accumulate unit over all 24 weights, one product per cycle. It emits operand selects, accumulator strobes and writeback strobes for the hidden registers (neurons 4-7) and output registers (neurons 8-9), and raises `out0_ready`/`out1_ready` as results land. It sits between the input-capture logic (`in_ready`) and the MAC/register datapath.

## Interface
- `ACC_LAT`, default 0: extra MAC pipeline cycles to wait after the last accumulate before each writeback (0..7).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_ready`  in  1  start request; sampled only in IDLE.
- `stall`  in  1  datapath back-pressure; the presented op is not consumed this cycle.
- `busy`  out  1  inference in progress.
- `layer`  out  1  0 = input→hidden (x0..x3, w_i4..w_i7); 1 = hidden→output (h4..h7, w_48..w_79).
- `src_idx`  out  2  source operand index i (x_i in layer 0, hidden h_(4+i) in layer 1).
- `dst_idx`  out  2  destination neuron: 4+dst in layer 0, 8+dst in layer 1 (0..1).
- `acc_clr`  out  1  acc ← x·w (load first product).
- `acc_en`  out  1  acc ← acc + x·w.
- `h_we`  out  1  hidden[dst_idx] ← acc.
- `out_we`  out  1  out[dst_idx] ← acc.
- `out0_ready`, `out1_ready`  out  1  one-cycle pulse: out0/out1 register updated.

Weight addressed by the datapath = w_(src)(4+dst) in layer 0 and w_(4+src)(8+dst) in layer 1.

## Operation
- States: IDLE, MAC, DRAIN, WB.
- IDLE → MAC on `in_ready`=1. Counters are set to layer=0, dst=0, src=0. `in_ready` is ignored outside IDLE; there is no queueing.
- MAC presents `src_idx`=0..3 in order. `acc_clr`=1 with src=0; `acc_en`=1 with src=1..3. After src=3 is consumed, go to DRAIN if ACC_LAT>0, else to WB.
- DRAIN runs ACC_LAT cycles with all strobes 0, then goes to WB.
- WB asserts `h_we` (layer 0) or `out_we` (layer 1) for one consumed cycle. It then advances dst. After layer 0 dst=3 it goes to layer 1, dst=0. After layer 1 dst=1 it goes to IDLE.
- Each op is consumed at a rising edge where `stall`=0. While `stall`=1, every output (strobes and indices) holds its value and no counter moves. The datapath gates its strobes with !stall.
- DRAIN counts only non-stalled cycles.
- `out0_ready`/`out1_ready` pulse in the cycle after the consuming edge of the layer-1 dst=0/1 writeback. The pulse is not held by stall.
- `busy` is 1 from the cycle after acceptance through the final WB cycle. It is 0 in the cycle carrying `out1_ready`, and the block is back in IDLE then. A new `in_ready` may be accepted at that edge.
- Reset (any time, mid-op included): state IDLE. All outputs 0 (`busy`, `layer`, `src_idx`, `dst_idx`, all strobes, ready pulses). An aborted inference produces no ready pulse and needs a fresh `in_ready`.

## Timing
- All outputs are registered. Cycle n is the period after edge n. Figures below assume `in_ready` accepted at edge 0, `stall`=0, ACC_LAT=0.
- Layer 0, neuron j: issue cycles 5j+1..5j+4 (src 0..3), WB cycle 5j+5, for j=0..3. Cycles 1-20.
- Layer 1, neuron k: issue cycles 21+5k..24+5k, WB cycle 25+5k. Cycles 21-30.
- `out0_ready`=1 in cycle 26 only. `out1_ready`=1 in cycle 31 only.
- `busy`=1 in cycles 1-30.
- Total latency: 31 cycles. General form: 6 × (5+ACC_LAT) + 1 + stalled cycles.
- Back-to-back: `in_ready` held high gives the next acc_clr in cycle 32.

## Test plan
- Basic run: reset, then one `in_ready` pulse at edge 0 with stall=0. Required: acc_clr in cycles 1,6,11,16,21,26; h_we in cycles 5,10,15,20 with dst 0..3; out_we in cycles 25/30 with dst 0/1; out0_ready in cycle 26; out1_ready in cycle 31; busy=1 exactly in cycles 1-30.
- End-to-end with a behavioural MAC: x=1,2,3,4, all layer-0 weights=1, all layer-1 weights=2. Required: each hidden = 10, out0 = out1 = 80.
- Stall: stall=1 during cycles 7-9. Required: outputs frozen at layer 0, dst=1, src=1 for cycles 7-10; all later events shift by +3; out1_ready in cycle 34.
- ACC_LAT=2: required WB cycles 7,14,21,28,35,42; out1_ready in cycle 43; no strobes during DRAIN.
- Ignore and abort: `in_ready` pulsed in cycle 12 changes nothing. Then rst_n low in cycle 23. Required: all outputs 0 immediately, no ready pulses after release, and the next `in_ready` restarts at layer 0, dst 0.
- Back-to-back: `in_ready` held high continuously. Required: out1_ready every 31 cycles; the next acc_clr coincides with the out1_ready cycle + 1.
